// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultDepthWords = 256;

  // Width of the word index for a given memory depth; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

  localparam int unsigned DefaultIdxW = idx_width(DefaultDepthWords);

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory request/response bundle.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        stall_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, stall_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, stall_o
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  localparam int unsigned IdxW = idx_width(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            i_we,
  input  logic            i_re,
  input  logic [IdxW-1:0] i_idx,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Write port and read register share the index; the FSM never asserts both at once.
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: holds the pipeline for LATENCY cycles per access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  parameter int unsigned LATENCY     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxW = idx_width(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CntW-1:0] CntInit = (LATENCY >= 2) ? CntW'(LATENCY - 2) : '0;

  if (LATENCY < 1) begin : gen_bad_latency
    $error("dmem_responder: LATENCY must be >= 1");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : gen_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_we;
  logic [IdxW-1:0] r_idx;
  logic [31:0]     r_wdata;
  logic            r_ack;
  logic            r_rd_valid;

  logic            w_stall;
  logic            w_accept;
  logic            w_commit;
  logic            w_we_c;
  logic [IdxW-1:0] w_idx_in, w_idx_c;
  logic [31:0]     w_wdata_c;
  logic [31:0]     w_arr_rdata;
  logic            w_unused_addr;

  assign w_idx_in      = bus.addr_i[IdxW+1:2];
  assign w_unused_addr = ^{bus.addr_i[31:IdxW+2], bus.addr_i[1:0]};
  assign w_accept      = (r_state == StIdle) && bus.req_i;

  // With LATENCY = 1 the commit happens on the accepting edge, so use the live inputs.
  assign w_we_c    = (r_state == StIdle) ? bus.we_i    : r_we;
  assign w_idx_c   = (r_state == StIdle) ? w_idx_in    : r_idx;
  assign w_wdata_c = (r_state == StIdle) ? bus.wdata_i : r_wdata;

  // Commit on the edge entering DONE; gated by reset because the array itself is never reset.
  assign w_commit = rst_i &&
                    (((r_state == StBusy) && (r_cnt == '0)) || ((LATENCY == 1) && w_accept));

  // Next-state, countdown and stall decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_stall = bus.req_i;
        if (bus.req_i) begin
          if (LATENCY == 1) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StBusy;
            w_cnt_next   = CntInit;
          end
        end
      end
      StBusy: begin
        w_stall = 1'b1;
        if (r_cnt == '0) w_state_next = StDone;
        else             w_cnt_next   = r_cnt - CntW'(1);
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM, counter, request capture and completion flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_ack      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= (w_state_next == StDone);
      if (w_accept) begin
        r_we    <= bus.we_i;
        r_idx   <= w_idx_in;
        r_wdata <= bus.wdata_i;
      end
      if (w_commit && !w_we_c) r_rd_valid <= 1'b1;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .i_we   (w_commit && w_we_c),
    .i_re   (w_commit && !w_we_c),
    .i_idx  (w_idx_c),
    .i_wdata(w_wdata_c),
    .o_rdata(w_arr_rdata)
  );

  // Read data reads as zero until the first load after reset; stores leave it untouched.
  assign bus.rdata_o = r_rd_valid ? w_arr_rdata : 32'h0;
  assign bus.ack_o   = r_ack;
  assign bus.stall_o = w_stall && rst_i;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised + directed bench for dmem_responder with a timestamp-based reference model.
module tb_dmem_responder;

  localparam int unsigned DepthA = 256;
  localparam int unsigned LatA   = 4;
  localparam int unsigned DepthB = 16;
  localparam int unsigned LatB   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(DepthA), .LATENCY(LatA)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(DepthB), .LATENCY(LatB)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit done_a = 1'b0;
  bit done_b = 1'b0;

  // Reference model: acceptance timestamp per instance, word store with known-flags.
  int          t_acc  [2];
  logic        m_we   [2];
  int unsigned m_idx  [2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_rd   [2];
  bit          m_rdk  [2];
  logic [31:0] mm     [2][256];
  bit          mk     [2][256];

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? LatA : LatB;
  endfunction

  function automatic int unsigned depth_of(input int k);
    return (k == 0) ? DepthA : DepthB;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %08h want %08h", name, cyc, act, exp);
    end
  endtask

  // Compare one cycle of outputs, then advance the model across the coming edge.
  task automatic model_step(input int k, input logic rst, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic stall, input logic ack, input logic [31:0] rdata);
    int          l = int'(lat_of(k));
    int unsigned d = depth_of(k);
    logic        e_stall, e_ack;
    if (!rst) begin
      t_acc[k] = -1;
      m_rd[k]  = 32'h0;
      m_rdk[k] = 1'b1;
      e_stall  = 1'b0;
      e_ack    = 1'b0;
    end else if (t_acc[k] >= 0 && cyc < t_acc[k] + l) begin
      e_stall = 1'b1;
      e_ack   = 1'b0;
    end else if (t_acc[k] >= 0 && cyc == t_acc[k] + l) begin
      e_stall = 1'b0;
      e_ack   = 1'b1;
    end else begin
      e_stall = req;
      e_ack   = 1'b0;
    end
    chk($sformatf("stall%0d", k), 32'(stall), 32'(e_stall));
    chk($sformatf("ack%0d", k), 32'(ack), 32'(e_ack));
    if (m_rdk[k]) chk($sformatf("rdata%0d", k), rdata, m_rd[k]);
    if (rst) begin
      if (t_acc[k] >= 0 && cyc == t_acc[k] + l) begin
        t_acc[k] = -1;
      end else if (t_acc[k] < 0 && req) begin
        t_acc[k]   = cyc;
        m_we[k]    = we;
        m_idx[k]   = (addr >> 2) % d;
        m_wdata[k] = wdata;
      end
      if (t_acc[k] >= 0 && cyc == t_acc[k] + l - 1) begin
        if (m_we[k]) begin
          mm[k][m_idx[k]] = m_wdata[k];
          mk[k][m_idx[k]] = 1'b1;
        end else begin
          m_rd[k]  = mm[k][m_idx[k]];
          m_rdk[k] = mk[k][m_idx[k]];
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      t_acc[k] = -1;
      m_rd[k]  = 32'h0;
      m_rdk[k] = 1'b1;
      for (int i = 0; i < 256; i++) mk[k][i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      model_step(0, rst_a, bus_a.req_i, bus_a.we_i, bus_a.addr_i, bus_a.wdata_i,
                 bus_a.stall_o, bus_a.ack_o, bus_a.rdata_o);
      model_step(1, rst_b, bus_b.req_i, bus_b.we_i, bus_b.addr_i, bus_b.wdata_i,
                 bus_b.stall_o, bus_b.ack_o, bus_b.rdata_o);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (k == 0) begin
      bus_a.req_i = req; bus_a.we_i = we; bus_a.addr_i = addr; bus_a.wdata_i = wdata;
    end else begin
      bus_b.req_i = req; bus_b.we_i = we; bus_b.addr_i = addr; bus_b.wdata_i = wdata;
    end
  endtask

  task automatic set_rst(input int k, input logic v);
    if (k == 0) rst_a = v;
    else        rst_b = v;
  endtask

  task automatic get(input int k, output logic s, output logic a, output logic [31:0] r);
    if (k == 0) begin s = bus_a.stall_o; a = bus_a.ack_o; r = bus_a.rdata_o; end
    else        begin s = bus_b.stall_o; a = bus_b.ack_o; r = bus_b.rdata_o; end
  endtask

  // One access issued in an IDLE cycle; returns read data and cycles until ack.
  task automatic access(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output int lat);
    logic s, a;
    logic [31:0] r;
    drive(k, 1'b1, we, addr, wdata);
    #1;
    get(k, s, a, r);
    chk("acc_stall", 32'(s), 32'd1);
    lat = 0;
    rd  = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      drive(k, 1'b0, 1'($urandom), $urandom, $urandom);
      #1;
      get(k, s, a, r);
      if (a) begin
        lat = n;
        rd  = r;
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic rand_phase(input int k, input int n);
    int unsigned d = depth_of(k);
    logic [31:0] rd, addr;
    int          lat;
    for (int i = 0; i < 8; i++) access(k, 1'b1, 32'(i * 4), $urandom, rd, lat);
    for (int i = 0; i < n; i++) begin
      tick();
      set_rst(k, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
      addr = ($urandom & ~((d - 1) << 2)) | (32'($urandom_range(0, 7)) << 2);
      drive(k, 1'($urandom_range(0, 2) != 0), 1'($urandom), addr, $urandom);
    end
    tick();
    set_rst(k, 1'b1);
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (lat_of(k) + 3) tick();
  endtask

  // Instance A: LATENCY = 4, DEPTH_WORDS = 256.
  initial begin
    logic s, a;
    logic [31:0] r, rd;
    int lat;
    drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    repeat (3) begin
      tick();
      #1;
      get(0, s, a, r);
      chk("rst_rdata", r, 32'h0);
      chk("rst_ack", 32'(a), 32'd0);
      chk("rst_stall", 32'(s), 32'd0);
    end
    tick();
    rst_a = 1'b1;
    #1;
    get(0, s, a, r);
    chk("rel_stall", 32'(s), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      #1;
      get(0, s, a, r);
      chk("busy_stall", 32'(s), 32'd1);
      chk("busy_ack", 32'(a), 32'd0);
    end
    tick();
    drive(0, 1'b1, 1'b0, 32'h0000_0999, 32'h0);
    #1;
    get(0, s, a, r);
    chk("st_ack", 32'(a), 32'd1);
    chk("st_stall", 32'(s), 32'd0);
    tick();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 6; i <= 8; i++) begin
      tick();
      drive(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
    end
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    get(0, s, a, r);
    chk("ld_ack", 32'(a), 32'd1);
    chk("ld_rdata", r, 32'hDEADBEEF);
    tick();

    access(0, 1'b1, 32'h400, 32'hA5A5A5A5, rd, lat);
    chk("wrap_st_lat", 32'(lat), 32'd4);
    access(0, 1'b0, 32'h3, 32'h0, rd, lat);
    chk("wrap_ld_lat", 32'(lat), 32'd4);
    chk("wrap_rdata", rd, 32'hA5A5A5A5);

    access(0, 1'b1, 32'h20, 32'h22222222, rd, lat);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h11111111);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst_a = 1'b0;
    #1;
    get(0, s, a, r);
    chk("mr_ack", 32'(a), 32'd0);
    chk("mr_stall", 32'(s), 32'd0);
    chk("mr_rdata", r, 32'h0);
    tick();
    rst_a = 1'b1;
    repeat (3) begin
      tick();
      #1;
      get(0, s, a, r);
      chk("mr_noack", 32'(a), 32'd0);
    end
    access(0, 1'b0, 32'h20, 32'h0, rd, lat);
    chk("mr_keep", rd, 32'h22222222);

    rand_phase(0, 3000);
    done_a = 1'b1;
  end

  // Instance B: LATENCY = 1, DEPTH_WORDS = 16.
  initial begin
    logic [31:0] rd;
    int lat;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    access(1, 1'b1, 32'h0, 32'h12345678, rd, lat);
    chk("l1_st_lat", 32'(lat), 32'd1);
    access(1, 1'b0, 32'h0, 32'h0, rd, lat);
    chk("l1_ld_lat", 32'(lat), 32'd1);
    chk("l1_rdata", rd, 32'h12345678);
    access(1, 1'b1, 32'h44, 32'h0BADF00D, rd, lat);
    access(1, 1'b0, 32'h07, 32'h0, rd, lat);
    chk("l1_wrap", rd, 32'h0BADF00D);
    rand_phase(1, 3000);
    done_b = 1'b1;
  end

  initial begin
    wait (done_a && done_b);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
